// File: rtl/output_requant_fifo.sv
// Requantising output buffer: optional ReLU, rounded arithmetic right shift and
// saturation, followed by a show-ahead FIFO with sticky overflow and frame pulse.
module output_requant_fifo #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int FIFO_DEPTH         = 8,
  parameter int SHIFT_WIDTH        = 5,
  localparam int X_W = $clog2(FEATURE_MAP_WIDTH),
  localparam int Y_W = $clog2(FEATURE_MAP_HEIGHT),
  localparam int C_W = $clog2(OUTPUT_NB_CHANNELS),
  localparam int PW  = $clog2(FIFO_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          relu_en,
  input  logic [SHIFT_WIDTH-1:0]        shift_amount,
  input  logic [ACCUMULATION_WIDTH-1:0] in_data,
  input  logic                          in_valid,
  input  logic [X_W-1:0]                in_x,
  input  logic [Y_W-1:0]                in_y,
  input  logic [C_W-1:0]                in_ch,
  output logic [IO_DATA_WIDTH-1:0]      out_data,
  output logic [X_W-1:0]                out_x,
  output logic [Y_W-1:0]                out_y,
  output logic [C_W-1:0]                out_ch,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic                          frame_done,
  output logic [PW:0]                   fill_level
);

  localparam int AW         = ACCUMULATION_WIDTH;
  localparam int IW         = IO_DATA_WIDTH;
  localparam int FRAME_SIZE = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
  localparam int FW         = $clog2(FRAME_SIZE + 1);
  localparam logic signed [AW:0] SAT_MAX = {{(AW - IW + 2){1'b0}}, {(IW - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW - IW + 2){1'b1}}, {(IW - 1){1'b0}}};

  logic signed [AW-1:0] relu_val;
  logic signed [AW:0]   ext_val;
  logic signed [AW:0]   round_add;
  logic signed [AW:0]   sum_val;
  logic signed [AW:0]   shifted;
  logic [IW-1:0]        sat_val;

  // One extra bit of headroom keeps the rounding add from wrapping at the top of range.
  always_comb begin
    relu_val  = (relu_en && in_data[AW-1]) ? '0 : in_data;
    ext_val   = {relu_val[AW-1], relu_val};
    round_add = '0;
    if (shift_amount != '0)
      round_add = {{AW{1'b0}}, 1'b1} << (shift_amount - SHIFT_WIDTH'(1));
    sum_val = ext_val + round_add;
    shifted = sum_val >>> shift_amount;
    if (shifted > SAT_MAX)
      sat_val = SAT_MAX[IW-1:0];
    else if (shifted < SAT_MIN)
      sat_val = SAT_MIN[IW-1:0];
    else
      sat_val = shifted[IW-1:0];
  end

  logic           stage_valid;
  logic [IW-1:0]  stage_data;
  logic [X_W-1:0] stage_x;
  logic [Y_W-1:0] stage_y;
  logic [C_W-1:0] stage_ch;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
      stage_x     <= '0;
      stage_y     <= '0;
      stage_ch    <= '0;
    end else begin
      stage_valid <= in_valid;
      if (in_valid) begin
        stage_data <= sat_val;
        stage_x    <= in_x;
        stage_y    <= in_y;
        stage_ch   <= in_ch;
      end
    end
  end

  logic [IW-1:0]  mem_data [FIFO_DEPTH];
  logic [X_W-1:0] mem_x    [FIFO_DEPTH];
  logic [Y_W-1:0] mem_y    [FIFO_DEPTH];
  logic [C_W-1:0] mem_ch   [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;
  logic [IW-1:0]  last_data;
  logic [X_W-1:0] last_x;
  logic [Y_W-1:0] last_y;
  logic [C_W-1:0] last_ch;
  logic           full, pop, push, drop;

  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign full      = (count == (PW + 1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = stage_valid && (!full || pop);
  assign drop      = stage_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      last_data <= '0;
      last_x    <= '0;
      last_y    <= '0;
      last_ch   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_x[i]    <= '0;
        mem_y[i]    <= '0;
        mem_ch[i]   <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= stage_data;
        mem_x[wr_ptr]    <= stage_x;
        mem_y[wr_ptr]    <= stage_y;
        mem_ch[wr_ptr]   <= stage_ch;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_data <= mem_data[rd_ptr];
        last_x    <= mem_x[rd_ptr];
        last_y    <= mem_y[rd_ptr];
        last_ch   <= mem_ch[rd_ptr];
      end
      if (drop)
        overflow <= 1'b1;
      if (push && !pop)
        count <= count + (PW + 1)'(1);
      else if (!push && pop)
        count <= count - (PW + 1)'(1);
    end
  end

  // Outputs keep showing the most recently popped entry while the FIFO is empty.
  always_comb begin
    out_data = last_data;
    out_x    = last_x;
    out_y    = last_y;
    out_ch   = last_ch;
    if (out_valid) begin
      out_data = mem_data[rd_ptr];
      out_x    = mem_x[rd_ptr];
      out_y    = mem_y[rd_ptr];
      out_ch   = mem_ch[rd_ptr];
    end
  end

  assign fill_level = count;

  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        if (frame_cnt == FW'(FRAME_SIZE - 1)) begin
          frame_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_output_requant_fifo.sv
// Scoreboard bench for output_requant_fifo: a full-size instance for the data
// path and FIFO behaviour, and a tiny 2x2x2 instance for frame completion.
module tb_output_requant_fifo;

  typedef struct packed {
    logic [15:0] data;
    logic [6:0]  x;
    logic [6:0]  y;
    logic [3:0]  ch;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        relu_en;
  logic [4:0]  shift_amount;
  logic [31:0] in_data;
  logic        in_valid;
  logic [6:0]  in_x, in_y;
  logic [3:0]  in_ch;
  logic [15:0] out_data;
  logic [6:0]  out_x, out_y;
  logic [3:0]  out_ch;
  logic        out_valid, out_ready, overflow, frame_done;
  logic [3:0]  fill_level;

  logic        sm_in_valid;
  logic [31:0] sm_in_data;
  logic [0:0]  sm_in_x, sm_in_y, sm_in_ch;
  logic [15:0] sm_out_data;
  logic [0:0]  sm_out_x, sm_out_y, sm_out_ch;
  logic        sm_out_valid, sm_out_ready, sm_overflow, sm_frame_done;
  logic [3:0]  sm_fill_level;

  int     checks = 0;
  int     errors = 0;
  int     pop_count = 0;
  entry_t exp_q[$];
  entry_t mon_e;

  always #5 clk = ~clk;

  output_requant_fifo dut (
    .clk(clk), .rst_in(rst_in), .relu_en(relu_en), .shift_amount(shift_amount),
    .in_data(in_data), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .frame_done(frame_done), .fill_level(fill_level)
  );

  output_requant_fifo #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2)
  ) dut_small (
    .clk(clk), .rst_in(rst_in), .relu_en(1'b0), .shift_amount(5'd0),
    .in_data(sm_in_data), .in_valid(sm_in_valid), .in_x(sm_in_x), .in_y(sm_in_y),
    .in_ch(sm_in_ch), .out_data(sm_out_data), .out_x(sm_out_x), .out_y(sm_out_y),
    .out_ch(sm_out_ch), .out_valid(sm_out_valid), .out_ready(sm_out_ready),
    .overflow(sm_overflow), .frame_done(sm_frame_done), .fill_level(sm_fill_level)
  );

  // Reference requantiser in 64-bit arithmetic.
  function automatic logic [15:0] model(input logic signed [31:0] d, input bit relu, input int s);
    longint a, r;
    a = (relu && d < 0) ? 64'sd0 : longint'(d);
    if (s > 0) r = (a + (longint'(1) << (s - 1))) >>> s;
    else r = a;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [6:0] x, input logic [6:0] y,
                      input logic [3:0] c, input bit expect_it);
    entry_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_x     = x;
    in_y     = y;
    in_ch    = c;
    if (expect_it) begin
      e.data = model(d, relu_en, int'(shift_amount));
      e.x = x;
      e.y = y;
      e.ch = c;
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst_in && out_valid && out_ready) begin
      pop_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_unexpected: got %h/%0d/%0d/%0d, required no pop",
                 out_data, out_x, out_y, out_ch);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_data, out_x, out_y, out_ch} !== mon_e) begin
          errors++;
          $display("[TB] FAIL pop_entry: got %h/%0d/%0d/%0d, required %h/%0d/%0d/%0d",
                   out_data, out_x, out_y, out_ch, mon_e.data, mon_e.x, mon_e.y, mon_e.ch);
        end
      end
    end
  end

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    checks++;
    if ({out_valid, overflow, frame_done, fill_level} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got v=%b ov=%b fd=%b fill=%0d, required all 0",
               out_valid, overflow, frame_done, fill_level);
    end
    checks++;
    if ({out_data, out_x, out_y, out_ch} !== 34'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h/%0d/%0d/%0d, required 0",
               out_data, out_x, out_y, out_ch);
    end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_rounding();
    relu_en = 1'b0;
    shift_amount = 5'd4;
    out_ready = 1'b1;
    send(32'sd1000, 7'd3, 7'd4, 4'd5, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: got out_valid=%b at t+1, required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd63) begin
      errors++;
      $display("[TB] FAIL round_pos: got v=%b data=%0d at t+2, required v=1 data=63",
               out_valid, $signed(out_data));
    end
    tick();
    send(-32'sd1000, 7'd1, 7'd2, 4'd3, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFC2) begin
      errors++;
      $display("[TB] FAIL round_neg: got v=%b data=%0d, required v=1 data=-62",
               out_valid, $signed(out_data));
    end
    drain(10);
  endtask

  task automatic test_relu_sat();
    relu_en = 1'b1;
    shift_amount = 5'd0;
    send(-32'sd5, 7'd10, 7'd11, 4'd1, 1'b1);
    tick();
    checks++;
    if (out_data !== 16'd0) begin
      errors++;
      $display("[TB] FAIL relu_clamp: got %0d, required 0", $signed(out_data));
    end
    tick();
    relu_en = 1'b0;
    send(32'h7FFF_FFFF, 7'd20, 7'd21, 4'd2, 1'b1);
    tick();
    checks++;
    if (out_data !== 16'h7FFF) begin
      errors++;
      $display("[TB] FAIL sat_pos: got %0d, required 32767", $signed(out_data));
    end
    tick();
    send(32'h8000_0000, 7'd30, 7'd31, 4'd3, 1'b1);
    tick();
    checks++;
    if (out_data !== 16'h8000) begin
      errors++;
      $display("[TB] FAIL sat_neg: got %0d, required -32768", $signed(out_data));
    end
    drain(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL relu_sat_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    int pops_before;
    shift_amount = 5'd2;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      send(32'(i * 37 - 100), 7'(i), 7'(100 + i), 4'(i), i < 8);
    tick();
    tick();
    checks++;
    if (fill_level !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_full: got fill=%0d ov=%b, required fill=8 ov=1",
               fill_level, overflow);
    end
    pops_before = pop_count;
    out_ready = 1'b1;
    drain(20);
    checks++;
    if (pop_count - pops_before != 8 || fill_level !== 4'd0) begin
      errors++;
      $display("[TB] FAIL overflow_drain: got %0d pops fill=%0d, required 8 pops fill=0",
               pop_count - pops_before, fill_level);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_sticky: got %b, required 1", overflow);
    end
  endtask

  task automatic test_streaming();
    int pops_before;
    int max_fill;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    exp_q.delete();
    tick();
    shift_amount = 5'd3;
    out_ready = 1'b1;
    pops_before = pop_count;
    max_fill = 0;
    for (int i = 0; i < 100; i++) begin
      send($urandom, 7'(i), 7'(127 - i), 4'(i % 16), 1'b1);
      if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
    end
    drain(10);
    checks++;
    if (pop_count - pops_before != 100) begin
      errors++;
      $display("[TB] FAIL stream_pops: got %0d, required 100", pop_count - pops_before);
    end
    checks++;
    if (max_fill > 1 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_fill: got max_fill=%0d ov=%b, required <=1 ov=0",
               max_fill, overflow);
    end
  endtask

  task automatic test_reset_mid();
    shift_amount = 5'd1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'(i + 1), 7'(i), 7'(i), 4'(i), 1'b1);
    tick();
    checks++;
    if (fill_level !== 4'd5) begin
      errors++;
      $display("[TB] FAIL mid_queued: got fill=%0d, required 5", fill_level);
    end
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    exp_q.delete();
    checks++;
    if ({out_valid, fill_level, overflow} !== 6'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got v=%b fill=%0d ov=%b, required all 0",
               out_valid, fill_level, overflow);
    end
    out_ready = 1'b1;
    send(32'sd41, 7'd9, 7'd8, 4'd7, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_latency_early: got out_valid=%b, required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd21 || out_x !== 7'd9) begin
      errors++;
      $display("[TB] FAIL mid_after: got v=%b data=%0d x=%0d, required v=1 data=21 x=9",
               out_valid, out_data, out_x);
    end
    drain(10);
  endtask

  task automatic test_frame_done();
    int  sent = 0;
    int  pops = 0;
    int  pulses = 0;
    bit  expect_fd = 0;
    bit  after_last = 0;
    bit  finished = 0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(posedge clk);
      #1;
      sm_in_valid = (sent < 8) || (sent == 8 && pops >= 8);
      if (sm_in_valid) begin
        sm_in_data = 32'(sent);
        sm_in_x = 1'(sent);
        sm_in_y = 1'(sent >> 1);
        sm_in_ch = 1'(sent >> 2);
        sent++;
      end
      sm_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (sm_frame_done !== expect_fd) begin
        errors++;
        $display("[TB] FAIL frame_done: got %b after pop %0d, required %b",
                 sm_frame_done, pops, expect_fd);
      end
      if (sm_frame_done) pulses++;
      if (after_last) finished = 1;
      expect_fd = 0;
      if (sm_out_valid && sm_out_ready) begin
        pops++;
        expect_fd = (pops == 8);
        if (pops == 9) after_last = 1;
      end
    end
    sm_in_valid = 1'b0;
    checks++;
    if (!finished || pulses != 1) begin
      errors++;
      $display("[TB] FAIL frame_pulses: got %0d pulses %0d pops, required 1 pulse 9 pops",
               pulses, pops);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    relu_en = 1'b0;
    shift_amount = '0;
    in_data = '0;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_ch = '0;
    out_ready = 1'b0;
    sm_in_valid = 1'b0;
    sm_in_data = '0;
    sm_in_x = '0;
    sm_in_y = '0;
    sm_in_ch = '0;
    sm_out_ready = 1'b0;
    test_reset();
    test_rounding();
    test_relu_sat();
    test_overflow();
    test_streaming();
    test_reset_mid();
    test_frame_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
